// File: rtl/rectangle_pkg.sv
// Shared constants for the RECTANGLE-80 round datapath: S-box, rotate amounts, round-constant seed.
// Used by rectangle_sbox and rectangle_round_core (optional pipelining macro: RECTANGLE_ROUND_PIPE_EN).
package rectangle_pkg;

    typedef logic [15:0] row_t;
    typedef logic [3:0]  nibble_t;

    localparam nibble_t SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    localparam int SHIFT_ROW0 = 0;
    localparam int SHIFT_ROW1 = 1;
    localparam int SHIFT_ROW2 = 12;
    localparam int SHIFT_ROW3 = 13;

    localparam int KEY_ROT_R0 = 8;
    localparam int KEY_ROT_R3 = 12;

    localparam logic [4:0] RC_INIT = 5'h01;
    localparam int         ROUNDS  = 25;

    // Left rotate of a 16-bit row; amounts are always constants, so this is pure wiring.
    function automatic row_t rotl16(input row_t v, input int n);
        row_t hi;
        row_t lo;
        hi = v << n;
        lo = (n == 0) ? 16'h0000 : (v >> (16 - n));
        return hi | lo;
    endfunction

endpackage

// File: rtl/rectangle_sbox.sv
// RECTANGLE 4-bit S-box; column nibble in, substituted nibble out.
module rectangle_sbox
    import rectangle_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/rectangle_round_core.sv
// One RECTANGLE-80 round: AddRoundKey, SubColumn, ShiftRow, key schedule and round-constant LFSR.
// Define RECTANGLE_ROUND_PIPE_EN to register all outputs (1-cycle latency, synchronous reset).
module rectangle_round_core
    import rectangle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] res,
    input  logic [79:0] k,
    input  logic [4:0]  cnt,
    input  logic [4:0]  rc,
    output logic [63:0] te,
    output logic [79:0] r_keys,
    output logic [4:0]  rc1
);

    row_t    x_row     [4];
    row_t    sub_row   [4];
    row_t    shift_row [4];
    nibble_t state_col [16];

    row_t    key_row   [5];
    row_t    key_sub   [4];
    row_t    key_next  [5];
    nibble_t key_col   [4];

    logic [63:0] te_next;
    logic [79:0] r_keys_next;
    logic [4:0]  rc1_next;

    // Row 0 is the most significant 16 bits of both the state and the key register.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x_row[i] = '0;
        end
        for (int i = 0; i < 5; i++) begin
            key_row[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            x_row[i] = res[63 - 16*i -: 16] ^ k[79 - 16*i -: 16];
        end
        for (int i = 0; i < 5; i++) begin
            key_row[i] = k[79 - 16*i -: 16];
        end
    end

    for (genvar j = 0; j < 16; j++) begin : g_state_sbox
        rectangle_sbox u_sbox (
            .din  ({x_row[3][j], x_row[2][j], x_row[1][j], x_row[0][j]}),
            .dout (state_col[j])
        );
    end

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        rectangle_sbox u_sbox (
            .din  ({key_row[3][j], key_row[2][j], key_row[1][j], key_row[0][j]}),
            .dout (key_col[j])
        );
    end

    // Scatter the substituted column nibbles back into rows, bit i of each nibble to row i.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sub_row[i] = '0;
            key_sub[i] = key_row[i];
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 16; j++) begin
                sub_row[i][j] = state_col[j][i];
            end
            for (int j = 0; j < 4; j++) begin
                key_sub[i][j] = key_col[j][i];
            end
        end
    end

    always_comb begin
        shift_row[0] = rotl16(sub_row[0], SHIFT_ROW0);
        shift_row[1] = rotl16(sub_row[1], SHIFT_ROW1);
        shift_row[2] = rotl16(sub_row[2], SHIFT_ROW2);
        shift_row[3] = rotl16(sub_row[3], SHIFT_ROW3);
        te_next = {shift_row[0], shift_row[1], shift_row[2], shift_row[3]};
    end

    // Generalised Feistel step on the partially substituted key; rc folds into the low bits of R0'.
    always_comb begin
        key_next[0] = rotl16(key_sub[0], KEY_ROT_R0) ^ key_sub[1];
        key_next[0][4:0] = key_next[0][4:0] ^ rc;
        key_next[1] = key_sub[2];
        key_next[2] = key_sub[3];
        key_next[3] = rotl16(key_sub[3], KEY_ROT_R3) ^ key_row[4];
        key_next[4] = key_sub[0];
        r_keys_next = {key_next[0], key_next[1], key_next[2], key_next[3], key_next[4]};
    end

    assign rc1_next = {rc[3:0], rc[4] ^ rc[2]};

    logic unused_cnt;
    assign unused_cnt = ^cnt;

`ifdef RECTANGLE_ROUND_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            te     <= '0;
            r_keys <= '0;
            rc1    <= RC_INIT;
        end else begin
            te     <= te_next;
            r_keys <= r_keys_next;
            rc1    <= rc1_next;
        end
    end
`else
    assign te     = te_next;
    assign r_keys = r_keys_next;
    assign rc1    = rc1_next;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_rectangle_round_core.sv
// Self-checking bench for rectangle_round_core: directed vectors, LFSR walk, 25-round encryptions, random rounds.
// Works for both the combinational build and the RECTANGLE_ROUND_PIPE_EN build.
module tb_rectangle_round_core;

    logic        clk;
    logic        rst;
    logic [63:0] res;
    logic [79:0] k;
    logic [4:0]  cnt;
    logic [4:0]  rc;
    logic [63:0] te;
    logic [79:0] r_keys;
    logic [4:0]  rc1;

    int checks = 0;
    int errors = 0;

    localparam bit [3:0] SB [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                     4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

    rectangle_round_core dut (
        .clk    (clk),
        .rst    (rst),
        .res    (res),
        .k      (k),
        .cnt    (cnt),
        .rc     (rc),
        .te     (te),
        .r_keys (r_keys),
        .rc1    (rc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] rot16(input logic [15:0] v, input int n);
        logic [31:0] t;
        t = {v, v} << n;
        return t[31:16];
    endfunction

    function automatic logic [4:0] model_rc(input logic [4:0] c);
        int ci;
        ci = int'(c);
        return 5'(((ci * 2) % 32) + (((ci / 16) + (ci / 4)) % 2));
    endfunction

    // Reference round written over flat bit positions: row r, column j lives at bit 48-16*r+j.
    function automatic void model_round(input logic [63:0] s, input logic [79:0] key, input logic [4:0] c,
                                        output logic [63:0] te_o, output logic [79:0] rk_o, output logic [4:0] rc_o);
        logic [63:0] x;
        logic [63:0] y;
        logic [79:0] kk;
        logic [3:0]  nib;
        logic [3:0]  sv;
        logic [15:0] n0;
        x = s ^ key[79:16];
        y = '0;
        for (int j = 0; j < 16; j++) begin
            nib = {x[j], x[16+j], x[32+j], x[48+j]};
            sv = SB[nib];
            y[48+j] = sv[0];
            y[32+j] = sv[1];
            y[16+j] = sv[2];
            y[j]    = sv[3];
        end
        te_o = {rot16(y[63:48], 0), rot16(y[47:32], 1), rot16(y[31:16], 12), rot16(y[15:0], 13)};
        kk = key;
        for (int j = 0; j < 4; j++) begin
            nib = {kk[16+j], kk[32+j], kk[48+j], kk[64+j]};
            sv = SB[nib];
            kk[64+j] = sv[0];
            kk[48+j] = sv[1];
            kk[32+j] = sv[2];
            kk[16+j] = sv[3];
        end
        n0 = rot16(kk[79:64], 8) ^ kk[63:48] ^ {11'd0, c};
        rk_o = {n0, kk[47:32], kk[31:16], rot16(kk[31:16], 12) ^ kk[15:0], kk[79:64]};
        rc_o = model_rc(c);
    endfunction

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive between edges; the sample point after the next rising edge suits both builds.
    task automatic applyStimulus(input logic [63:0] s, input logic [79:0] key, input logic [4:0] n, input logic [4:0] c);
        @(negedge clk);
        res = s;
        k   = key;
        cnt = n;
        rc  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic runEncrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] kr;
        logic [4:0]  c;
        logic [63:0] m_te;
        logic [79:0] m_rk;
        logic [4:0]  m_rc;
        s  = pt;
        kr = key;
        c  = 5'h01;
        for (int r = 0; r < 25; r++) begin
            applyStimulus(s, kr, 5'(r), c);
            model_round(s, kr, c, m_te, m_rk, m_rc);
            checkOutput("enc_te", {16'd0, te}, {16'd0, m_te});
            checkOutput("enc_rk", r_keys, m_rk);
            checkOutput("enc_rc1", {75'd0, rc1}, {75'd0, m_rc});
            s  = m_te;
            kr = m_rk;
            c  = m_rc;
        end
        checkOutput("enc_cipher", {16'd0, te ^ r_keys[79:16]}, {16'd0, s ^ kr[79:16]});
    endtask

    initial begin
        logic [63:0] rs;
        logic [79:0] rk;
        logic [4:0]  rcv;
        logic [63:0] m_te;
        logic [79:0] m_rk;
        logic [4:0]  m_rc;
        logic [4:0]  c;

        rst = 1'b0;
        res = '0;
        k   = '0;
        cnt = '0;
        rc  = '0;

`ifdef RECTANGLE_ROUND_PIPE_EN
        @(negedge clk);
        rst = 1'b1;
        res = {$urandom, $urandom};
        k   = {16'($urandom), $urandom, $urandom};
        rc  = 5'h1F;
        @(posedge clk);
        #1;
        checkOutput("rst_te", {16'd0, te}, 80'd0);
        checkOutput("rst_rk", r_keys, 80'd0);
        checkOutput("rst_rc1", {75'd0, rc1}, 80'd1);
        @(negedge clk);
        rst = 1'b0;
`endif

        applyStimulus(64'd0, 80'd0, 5'd0, 5'h01);
        checkOutput("zero_te", {16'd0, te}, {16'd0, 64'h0000_FFFF_FFFF_0000});
        checkOutput("zero_rk", r_keys, 80'h000E_000F_0000_0000_0000);
        checkOutput("zero_rc1", {75'd0, rc1}, 80'h02);

        applyStimulus(64'd0, 80'd0, 5'd1, 5'h10);
        checkOutput("lfsr_10", {75'd0, rc1}, 80'h01);
        applyStimulus(64'd0, 80'd0, 5'd2, 5'h04);
        checkOutput("lfsr_04", {75'd0, rc1}, 80'h09);
        applyStimulus(64'd0, 80'd0, 5'd3, 5'h00);
        checkOutput("lfsr_00", {75'd0, rc1}, 80'h00);

        c = 5'h01;
        for (int i = 1; i <= 31; i++) begin
            applyStimulus(64'd0, 80'd0, 5'(i % 26), c);
            checkOutput("lfsr_step", {75'd0, rc1}, {75'd0, model_rc(c)});
            c = model_rc(c);
        end
        checkOutput("lfsr_period", {75'd0, rc1}, 80'h01);

        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 80'd0, 5'd0, 5'h01);
        checkOutput("ones_te", {16'd0, te}, {16'd0, 64'h0000_FFFF_0000_0000});

        rk = {64'h0123_4567_89AB_CDEF, 16'($urandom)};
        applyStimulus(64'h0123_4567_89AB_CDEF, rk, 5'd7, 5'($urandom));
        checkOutput("rk_xor_te", {16'd0, te}, {16'd0, 64'h0000_FFFF_FFFF_0000});

        runEncrypt(64'd0, 80'd0);
        runEncrypt(64'hFFFF_FFFF_FFFF_FFFF, {80{1'b1}});

        for (int i = 0; i < 40; i++) begin
            rs  = {$urandom, $urandom};
            rk  = {16'($urandom), $urandom, $urandom};
            rcv = 5'($urandom);
            applyStimulus(rs, rk, 5'($urandom_range(25, 0)), rcv);
            model_round(rs, rk, rcv, m_te, m_rk, m_rc);
            checkOutput("rand_te", {16'd0, te}, {16'd0, m_te});
            checkOutput("rand_rk", r_keys, m_rk);
            checkOutput("rand_rc1", {75'd0, rc1}, {75'd0, m_rc});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
